sprite_rom_arbiter: RTL and testbench
=====================================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one synchronous single-port sprite/table ROM among NREQ requesters.
//  Sits between the VGA pixel pipeline (requester 0) and the game-logic blocks
//  (invader formation, laser, score table readers) and the ROM.
//  - Requester 0 has priority whenever it requests.
//  - Requesters 1..NREQ-1 share the ROM round-robin, and only during blanking.
//  - Read data is returned with a one-hot valid tag naming the owning requester.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  AW       10  ROM address width
//  DW       16  ROM data width
//  ROM_LAT  2   ROM read latency, cycles from rom_en/rom_addr to rom_data (1..4)
// PORTS
//  clk       in   1        system clock
//  rst       in   1        asynchronous, active-high reset
//  blank     in   1        1 = H/V blanking; 0 = active video (only req[0] may win)
//  req       in   NREQ     per-requester read request, level
//  addr      in   NREQ*AW  per-requester address; slice i = addr[i*AW +: AW]
//  gnt       out  NREQ     one-hot grant, combinational, this cycle
//  rom_en    out  1        registered ROM read enable
//  rom_addr  out  AW       registered ROM address
//  rom_data  in   DW       ROM read data, valid ROM_LAT cycles after rom_en
//  rd_valid  out  NREQ     registered one-hot return tag
//  rd_data   out  DW       registered return data
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, rr_ptr=1; tag pipeline cleared.
//  - gnt=0 while rst=1.
//  Grant, same cycle, combinational:
//  - If req[0]=1, gnt[0]=1.
//  - Else if blank=1, the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1,
//    ... over 1..NREQ-1 with wrap NREQ-1 -> 1, gets gnt[i]=1.
//  - Else gnt=0.
//  - At most one gnt bit is set per cycle. No request means no grant.
//  Round-robin pointer:
//  - On a grant to i>=1: rr_ptr <= i+1, or 1 when i=NREQ-1.
//  - A grant to requester 0 leaves rr_ptr unchanged.
//  Handshake:
//  - Requester holds req and addr stable until it sees gnt.
//  - A cycle with gnt[i]=1 completes that request. Keeping req high starts a new
//    request, so back-to-back grants are legal.
//  - The arbiter never drops a request. req changes without gnt are the
//    requester's error and are not checked.
//  ROM issue and tagging:
//  - Cycle t with gnt[i]=1 -> cycle t+1: rom_en=1, rom_addr=addr slice i.
//  - Cycle t with no grant -> cycle t+1: rom_en=0, rom_addr holds its last value.
//  - A tag shift register of depth ROM_LAT carries the one-hot grant alongside
//    the ROM access.
//  Return:
//  - rd_valid=tag and rd_data=rom_data are registered at cycle t+2+ROM_LAT.
//    Total latency is ROM_LAT+2 cycles from gnt.
//  - When no tag is present: rd_valid=0 and rd_data holds its last value.
//  - Throughput: 1 read per cycle. Returns arrive in grant order.
//  Boundaries:
//  - blank falls while a low-priority read is in flight: that read still
//    completes and returns.
//  - rst asserted mid-operation: all in-flight reads are discarded and no
//    rd_valid is produced for them.
//  - All requests low: rom_en=0 and the pipeline drains normally.
//  - NREQ=2: requester 1 wins on every blank cycle when req[0]=0.
// TESTING
//  1. Reset, then blank=1 and req=4'b1110 held 6 cycles
//     -> gnt sequence 0010,0100,1000,0010,0100,1000.
//     rd_valid follows the same sequence, starting 4 cycles after the first gnt
//     (ROM_LAT=2).
//  2. req=4'b1011 and blank=1
//     -> gnt=0001 every cycle while req[0]=1; rr_ptr does not change.
//     Drop req[0] -> gnt goes 0010 then 1000.
//  3. blank=0, req=4'b0110
//     -> gnt=0 and rom_en=0 on every cycle.
//     Raise blank -> gnt=0010 in that same cycle.
//  4. addr0=10'h155 granted at cycle t, ROM model returns ~addr
//     -> rom_addr=10'h155 at t+1; rd_valid=0001 and rd_data=16'hFEAA at t+4.
//  5. Three grants issued, rst pulsed at t+2
//     -> outputs go to 0 immediately.
//     No rd_valid is seen for the three reads, and rr_ptr=1 after release.
//  6. NREQ=2, ROM_LAT=1, blank toggling each cycle, req=2'b10
//     -> grants only on blank=1 cycles.
//     Each is returned 3 cycles later, with no lost or duplicated tag.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Sprite/table ROM arbiter.
// Requester 0 (pixel pipeline) always wins. Requesters 1..NREQ-1 share the ROM
// round-robin, and only while blank is high. Each grant issues one registered
// ROM read. The read data comes back with a one-hot tag that names the
// requester, ROM_LAT+2 cycles after the grant.
module sprite_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 10,
    parameter int DW      = 16,
    parameter int ROM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blank,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]    gnt,
    output logic               rom_en,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data,
    output logic [NREQ-1:0]    rd_valid,
    output logic [DW-1:0]      rd_data
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] gnt_c;
    logic [AW-1:0]   gnt_addr;
    logic            rom_en_q, rom_en_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [NREQ-1:0] rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;

    // Stage 0 holds the tag while the ROM sees the access (it lines up with
    // rom_en). Stage ROM_LAT lines up with rom_data.
    logic [NREQ-1:0] tag_q [ROM_LAT+1];
    logic [NREQ-1:0] tag_d [ROM_LAT+1];

    // Grant: requester 0 first. Otherwise, during blanking, search from rr_ptr
    // over 1..NREQ-1 and wrap around.
    always_comb begin
        int  idx;
        logic found;
        gnt_c = '0;
        found = 1'b0;
        idx   = 0;
        if (!rst) begin
            if (req[0]) begin
                gnt_c[0] = 1'b1;
            end else if (blank) begin
                for (int k = 0; k < NREQ - 1; k++) begin
                    idx = (int'(rr_ptr_q) - 1 + k) % (NREQ - 1) + 1;
                    if (!found && req[idx]) begin
                        gnt_c[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    end

    // Pointer moves just past the low-priority winner; a grant to 0 leaves it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 1; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                rr_ptr_d = (i == NREQ - 1) ? PW'(1) : PW'(i + 1);
            end
        end
    end

    // Address mux for the winner. Zero when there is no grant; rom_addr then holds.
    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                gnt_addr = addr[i*AW +: AW];
            end
        end
    end

    // Next-state values for the ROM issue, the tag shift and the return registers.
    always_comb begin
        rom_en_d   = |gnt_c;
        rom_addr_d = (|gnt_c) ? gnt_addr : rom_addr_q;
        tag_d[0]   = gnt_c;
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        rd_valid_d = tag_q[ROM_LAT];
        rd_data_d  = (|tag_q[ROM_LAT]) ? rom_data : rd_data_q;
    end

    // State registers. Reset discards every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= PW'(1);
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign gnt      = gnt_c;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter.
// Stimulus comes from a table of cycle vectors plus a few hand-written
// sequences. Expected grants are worked out by hand. Expected returns go into
// a scoreboard queue at grant time and are compared when they fall due.
module tb_sprite_rom_arbiter;

    typedef struct {
        logic       blank;
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [15:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;

    // NREQ=4, ROM_LAT=2 instance
    logic        blank;
    logic [3:0]  req;
    logic [39:0] addr4;
    logic [3:0]  gnt;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  rd_valid;
    logic [15:0] rd_data;
    logic [15:0] rp4_0, rp4_1;

    // NREQ=2, ROM_LAT=1 instance
    logic        blank2;
    logic [1:0]  req2;
    logic [19:0] addr2;
    logic [1:0]  gnt2;
    logic        rom_en2;
    logic [9:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic [1:0]  rd_valid2;
    logic [15:0] rd_data2;
    logic [15:0] rp2_0;

    logic [9:0]  a4 [4] = '{10'h155, 10'h021, 10'h032, 10'h3C3};

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    vec_t        vecs[$];
    sb_t         sbq[$];
    sb_t         sbq2[$];
    logic        exp_en;
    logic [9:0]  exp_addr;
    logic [15:0] exp_rd;

    always #5 clk = ~clk;

    assign addr4 = {a4[3], a4[2], a4[1], a4[0]};
    assign addr2 = {10'h2A5, 10'h0F0};

    sprite_rom_arbiter #(.NREQ(4), .AW(10), .DW(16), .ROM_LAT(2)) u4 (
        .clk(clk), .rst(rst), .blank(blank), .req(req), .addr(addr4),
        .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    sprite_rom_arbiter #(.NREQ(2), .AW(10), .DW(16), .ROM_LAT(1)) u2 (
        .clk(clk), .rst(rst), .blank(blank2), .req(req2), .addr(addr2),
        .gnt(gnt2), .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .rd_valid(rd_valid2), .rd_data(rd_data2)
    );

    // ROM models return ~addr with the right latency.
    always @(posedge clk) begin
        rp4_0 <= ~{6'b0, rom_addr};
        rp4_1 <= rp4_0;
        rp2_0 <= ~{6'b0, rom_addr2};
    end
    assign rom_data  = rp4_1;
    assign rom_data2 = rp2_0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [9:0] addr_of(input logic [3:0] g);
        logic [9:0] a;
        a = '0;
        for (int i = 0; i < 4; i++) if (g[i]) a = a4[i];
        return a;
    endfunction

    task automatic add_vec(input logic b, input logic [3:0] r, input logic [3:0] g);
        vec_t v;
        v.blank = b; v.req = r; v.gnt = g;
        vecs.push_back(v);
    endtask

    // One clock cycle on the NREQ=4 instance: drive the inputs, then check the grant, the ROM issue and the return.
    task automatic do_cycle(input logic b, input logic [3:0] r, input logic [3:0] eg);
        sb_t e;
        @(posedge clk);
        #1;
        blank = b;
        req   = r;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_en", 32'(rom_en), 32'(exp_en));
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(e.tag));
            chk("rd_data", 32'(rd_data), 32'(e.data));
            exp_rd = e.data;
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'h0);
            chk("rd_data_hold", 32'(rd_data), 32'(exp_rd));
        end
        if (eg != 4'b0) begin
            e.due  = cyc + 4;
            e.tag  = eg;
            e.data = ~{6'b0, addr_of(eg)};
            sbq.push_back(e);
            exp_en   = 1'b1;
            exp_addr = addr_of(eg);
        end else begin
            exp_en = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        int  grants2;
        int  returns2;
        sb_t e2;

        // Six grants in a row cycle through requesters 1, 2 and 3 twice.
        for (int i = 0; i < 2; i++) begin
            add_vec(1'b1, 4'b1110, 4'b0010);
            add_vec(1'b1, 4'b1110, 4'b0100);
            add_vec(1'b1, 4'b1110, 4'b1000);
        end
        // Requester 0 wins every cycle; once it drops, the pointer resumes where it left off.
        for (int i = 0; i < 3; i++) add_vec(1'b1, 4'b1011, 4'b0001);
        add_vec(1'b1, 4'b1010, 4'b0010);
        add_vec(1'b1, 4'b1010, 4'b1000);
        // Active video blocks low-priority requesters.
        for (int i = 0; i < 3; i++) add_vec(1'b0, 4'b0110, 4'b0000);
        add_vec(1'b1, 4'b0110, 4'b0010);
        add_vec(1'b1, 4'b0000, 4'b0000);
        add_vec(1'b1, 4'b0000, 4'b0000);
        // A single read from requester 0, then idle while it drains.
        add_vec(1'b0, 4'b0001, 4'b0001);
        for (int i = 0; i < 5; i++) add_vec(1'b0, 4'b0000, 4'b0000);
        // Assorted mixes of requests and blank.
        add_vec(1'b1, 4'b1111, 4'b0001);
        add_vec(1'b1, 4'b1110, 4'b0100);
        add_vec(1'b0, 4'b1010, 4'b0000);
        add_vec(1'b1, 4'b1000, 4'b1000);
        add_vec(1'b1, 4'b1010, 4'b0010);
        for (int i = 0; i < 5; i++) add_vec(1'b0, 4'b0000, 4'b0000);

        // Reset state: hold requests high and check that nothing is granted.
        rst    = 1'b1;
        blank  = 1'b1;
        req    = 4'b1111;
        blank2 = 1'b0;
        req2   = 2'b00;
        #12;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        req      = 4'b0000;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_rd   = '0;

        foreach (vecs[i]) do_cycle(vecs[i].blank, vecs[i].req, vecs[i].gnt);

        // Three grants in flight, then an asynchronous reset discards them.
        do_cycle(1'b1, 4'b1110, 4'b0100);
        do_cycle(1'b1, 4'b1110, 4'b1000);
        do_cycle(1'b1, 4'b0110, 4'b0010);
        do_cycle(1'b1, 4'b0000, 4'b0000);
        #1;
        req = 4'b1110;
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_rom_en", 32'(rom_en), 32'h0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'h0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
        chk("midrst_rd_data", 32'(rd_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0000;
        sbq.delete();
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_rd   = '0;
        // After release the pointer must be back at 1.
        do_cycle(1'b1, 4'b1110, 4'b0010);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 4'b0000, 4'b0000);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        // Two-requester variant with ROM_LAT=1 and blank toggling every cycle.
        grants2  = 0;
        returns2 = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            blank2 = (k % 2 == 0);
            req2   = (k < 8) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("n2_gnt", 32'(gnt2), (req2[1] && blank2) ? 32'h2 : 32'h0);
            if (sbq2.size() > 0 && sbq2[0].due == k) begin
                e2 = sbq2.pop_front();
                returns2++;
                chk("n2_rd_valid", 32'(rd_valid2), 32'(e2.tag));
                chk("n2_rd_data", 32'(rd_data2), 32'(e2.data));
            end else begin
                chk("n2_rd_valid_idle", 32'(rd_valid2), 32'h0);
            end
            if (req2[1] && blank2) begin
                e2.due  = k + 3;
                e2.tag  = 4'b0010;
                e2.data = 16'hFD5A;
                sbq2.push_back(e2);
                grants2++;
            end
        end
        chk("n2_returns", 32'(returns2), 32'(grants2));
        chk("n2_grants", 32'(grants2), 32'd4);
        chk("n2_sb_drained", 32'(sbq2.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
